// File: rtl/morse_sequencer.sv
// Morse symbol sequencer: plays a packed dot/dash/letter-gap pattern as a
// timed tone. The unit length is a latched, runtime-programmable number of clocks.
// A start/busy/done handshake frames each playback, and abort cancels it.
module morse_sequencer #(
  parameter int MAX_SYM    = 5,
  parameter int DIV_W      = 25,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [2*MAX_SYM-1:0]         pattern,
  input  logic [DIV_W-1:0]             div,
  output logic                         tone,
  output logic                         is_dash,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_SYM+1)-1:0] sym_idx
);

  localparam int PAT_W     = 2 * MAX_SYM;
  localparam int SYM_W     = $clog2(MAX_SYM + 1);
  localparam int MAX_UNITS = (DASH_UNITS > GAP_UNITS) ? DASH_UNITS : GAP_UNITS;
  localparam int UNIT_W    = $clog2(MAX_UNITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_TONE,
    S_SPACE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PAT_W-1:0]   shreg;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   presc;
  logic [UNIT_W-1:0]  units;
  logic               dash_q;
  logic [1:0]         code;
  logic               timed;
  logic               tick;
  logic               last_unit;
  logic               fetch_end;

  // The symbol under decode always sits in the top pair of the shift register.
  assign code      = shreg[PAT_W-1 -: 2];
  assign timed     = (state == S_TONE) || (state == S_SPACE);
  assign tick      = timed && (presc == div_q);
  assign last_unit = tick && (units == UNIT_W'(1));
  assign fetch_end = (sym_idx == SYM_W'(MAX_SYM)) || (code == 2'b00);

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode; abort cancels any active playback.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (state == S_IDLE) begin
      if (start && !abort) state_next = S_FETCH;
    end else if (abort) begin
      state_next = S_IDLE;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (fetch_end)             state_next = S_DONE;
          else if (code == 2'b11)    state_next = S_SPACE;
          else                       state_next = S_TONE;
        end
        S_TONE:  if (last_unit) state_next = S_SPACE;
        S_SPACE: if (last_unit) state_next = S_FETCH;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: latched pattern/divider, prescaler, unit counter, symbol count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      div_q   <= '0;
      presc   <= '0;
      units   <= '0;
      dash_q  <= 1'b0;
      sym_idx <= '0;
    end else begin
      // Prescaler restarts on every entry to a timed state so each unit is
      // exactly div_q+1 cycles long.
      if (timed && (state_next == state)) presc <= tick ? '0 : presc + DIV_W'(1);
      else                                presc <= '0;

      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            shreg   <= pattern;
            div_q   <= div;
            sym_idx <= '0;
          end
        end
        S_FETCH: begin
          // Consume the symbol only when it actually starts a tone or gap.
          if ((state_next == S_TONE) || (state_next == S_SPACE)) begin
            shreg   <= shreg << 2;
            sym_idx <= sym_idx + SYM_W'(1);
            dash_q  <= (code == 2'b10);
            unique case (code)
              2'b01:   units <= UNIT_W'(1);
              2'b10:   units <= UNIT_W'(DASH_UNITS);
              default: units <= UNIT_W'(GAP_UNITS);
            endcase
          end
        end
        S_TONE: begin
          // The last tone unit hands over a one-unit inter-element gap.
          if (tick) units <= last_unit ? UNIT_W'(1) : units - UNIT_W'(1);
        end
        S_SPACE: begin
          if (tick) units <= units - UNIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output decode straight from the current state.
  always_comb begin
    tone    = (state == S_TONE);
    is_dash = (state == S_TONE) && dash_q;
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer: a symbol-level timeline model
// predicts every cycle of tone/is_dash/busy/done/sym_idx after each start.
module tb_morse_sequencer;

  localparam int MAX_SYM = 5;
  localparam int DIV_W   = 25;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [9:0]       pattern = '0;
  logic [DIV_W-1:0] div = '0;
  logic             tone;
  logic             is_dash;
  logic             busy;
  logic             done;
  logic [2:0]       sym_idx;

  int n_checks = 0;
  int n_errors = 0;
  int last_idx = 0;

  typedef struct packed {
    logic       tone;
    logic       dash;
    logic       busy;
    logic       done;
    logic [2:0] idx;
  } exp_t;

  exp_t exp_q[$];

  morse_sequencer #(.MAX_SYM(MAX_SYM), .DIV_W(DIV_W), .DASH_UNITS(3), .GAP_UNITS(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .div     (div),
    .tone    (tone),
    .is_dash (is_dash),
    .busy    (busy),
    .done    (done),
    .sym_idx (sym_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic t, input logic d, input logic b, input logic dn, input int idx);
    exp_t e;
    e.tone = t;
    e.dash = d;
    e.busy = b;
    e.done = dn;
    e.idx  = 3'(idx);
    return e;
  endfunction

  // Timeline of the cycles following the start edge: each symbol costs one
  // fetch cycle plus its units of tone/silence; unit = div+1 cycles.
  function automatic void build(input logic [9:0] pat, input int dv);
    int         unit;
    int         fin;
    logic [1:0] c;
    unit = dv + 1;
    fin  = 0;
    exp_q.delete();
    for (int k = 0; k <= MAX_SYM; k++) begin
      exp_q.push_back(mk(0, 0, 1, 0, k));
      fin = k;
      if (k == MAX_SYM) break;
      c = pat[2*(MAX_SYM-1-k) +: 2];
      if (c == 2'b00) break;
      case (c)
        2'b01: begin
          repeat (unit)     exp_q.push_back(mk(1, 0, 1, 0, k + 1));
          repeat (unit)     exp_q.push_back(mk(0, 0, 1, 0, k + 1));
        end
        2'b10: begin
          repeat (3 * unit) exp_q.push_back(mk(1, 1, 1, 0, k + 1));
          repeat (unit)     exp_q.push_back(mk(0, 0, 1, 0, k + 1));
        end
        default: begin
          repeat (3 * unit) exp_q.push_back(mk(0, 0, 1, 0, k + 1));
        end
      endcase
    end
    exp_q.push_back(mk(0, 0, 1, 1, fin));
    exp_q.push_back(mk(0, 0, 0, 0, fin));
  endfunction

  task automatic compare_exp(input exp_t e, input string name);
    check({name, ".tone"},    32'(tone),    32'(e.tone));
    check({name, ".is_dash"}, 32'(is_dash), 32'(e.dash));
    check({name, ".busy"},    32'(busy),    32'(e.busy));
    check({name, ".done"},    32'(done),    32'(e.done));
    check({name, ".sym_idx"}, 32'(sym_idx), 32'(e.idx));
  endtask

  task automatic idle_checks(input string name, input int n, input int idx);
    repeat (n) begin
      @(posedge clk); #1;
      check({name, ".idle_busy"}, 32'(busy), 32'd0);
      check({name, ".idle_done"}, 32'(done), 32'd0);
      check({name, ".idle_idx"},  32'(sym_idx), 32'(idx));
    end
  endtask

  // One playback; optionally aborts or resets at timeline index abort_at /
  // reset_at, scrambles inputs (incl. start) while busy, or holds start in DONE.
  task automatic play(input logic [9:0] pat, input int dv, input int abort_at,
                      input int reset_at, input bit noise, input bit start_at_done,
                      input string name);
    build(pat, dv);
    pattern = pat;
    div     = DIV_W'(dv);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      compare_exp(exp_q[i], name);
      if (i == abort_at) begin
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check({name, ".abort_tone"}, 32'(tone),    32'd0);
        check({name, ".abort_dash"}, 32'(is_dash), 32'd0);
        check({name, ".abort_busy"}, 32'(busy),    32'd0);
        check({name, ".abort_done"}, 32'(done),    32'd0);
        last_idx = int'(exp_q[i].idx);
        idle_checks({name, ".post_abort"}, 3, last_idx);
        return;
      end
      if (i == reset_at) begin
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        compare_exp(mk(0, 0, 0, 0, 0), {name, ".rst"});
        last_idx = 0;
        idle_checks({name, ".post_rst"}, 3, 0);
        return;
      end
      if (noise && (i < exp_q.size() - 1)) begin
        start   = 1'($urandom_range(0, 1));
        pattern = 10'($urandom);
        div     = DIV_W'($urandom);
      end
      if (start_at_done && exp_q[i].done) start = 1'b1;
      if (i == exp_q.size() - 1) start = 1'b0;
      @(posedge clk); #1;
    end
    last_idx = int'(exp_q[exp_q.size()-1].idx);
    check({name, ".post_busy"}, 32'(busy), 32'd0);
    check({name, ".post_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_exp(mk(0, 0, 0, 0, 0), "reset");
    reset = 1'b1;
    @(posedge clk); #1;
    compare_exp(mk(0, 0, 0, 0, 0), "after_reset");

    // Dot then dash at div=0; dot at div=3; unterminated run of letter gaps.
    play(10'b01_10_00_00_00, 0, -1, -1, 1'b0, 1'b0, "t1");
    play(10'b01_00_00_00_00, 3, -1, -1, 1'b0, 1'b0, "t2");
    play(10'b11_11_11_11_11, 0, -1, -1, 1'b0, 1'b0, "t3");
    // Inputs scrambled and start re-pulsed throughout playback.
    play(10'b10_10_01_00_00, 1, -1, -1, 1'b1, 1'b0, "t4");
    // Abort in the middle of a dash, then a normal playback.
    play(10'b10_01_00_00_00, 2, 3, -1, 1'b0, 1'b0, "t5");
    play(10'b01_01_11_10_00, 0, -1, -1, 1'b0, 1'b0, "t5b");

    // Abort together with start in IDLE: nothing latched, sym_idx untouched.
    pattern = 10'b10_10_10_10_10;
    div     = '0;
    start   = 1'b1;
    abort   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_abort.busy", 32'(busy), 32'd0);
    check("idle_abort.idx",  32'(sym_idx), 32'(last_idx));
    idle_checks("idle_abort", 2, last_idx);

    // Reset held one cycle mid-playback, then a fresh playback from index 0.
    play(10'b01_10_11_01_00, 1, -1, 6, 1'b0, 1'b0, "t6");
    play(10'b10_01_10_00_00, 1, -1, -1, 1'b0, 1'b0, "t6b");
    // start presented while DONE exits is ignored.
    play(10'b01_11_00_00_00, 0, -1, -1, 1'b0, 1'b1, "t7");
    play(10'b00_01_01_01_01, 2, -1, -1, 1'b0, 1'b0, "t8");

    for (int r = 0; r < 24; r++) begin
      logic [9:0] p;
      int         dv;
      int         ab;
      p  = 10'($urandom);
      dv = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      play(p, dv, ab, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
